// File: rtl/echo_tof_detector.sv
// echo_tof_detector: drains one receiver channel FIFO, rectifies samples about
// mid-scale, finds the first qualified echo after a blanking window and reports
// its time-of-flight (sample index) and peak magnitude once per transmit burst.
// Optional feature: define ECHO_AVG_EN to qualify hits on a 4-sample moving
// average of the magnitude instead of the raw magnitude. Peak always uses raw.
module echo_tof_detector #(
  parameter int          COUNT_BITS    = 16,
  parameter logic [15:0] MIDSCALE      = 16'h8000,
  parameter int          BLANK_SAMPLES = 64,
  parameter int          HOLD_SAMPLES  = 3,
  parameter int          PEAK_WINDOW   = 32,
  parameter int          MAX_SAMPLES   = 4000
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic                  ON,
  input  logic                  TX_START,
  input  logic                  CHANNEL_EMPTY,
  input  logic [15:0]           CHANNEL_DATA,
  output logic                  READ_REQ,
  input  logic [15:0]           THRESHOLD,
  output logic                  ECHO_VALID,
  output logic [COUNT_BITS-1:0] ECHO_TOF,
  output logic [15:0]           ECHO_PEAK,
  output logic                  TIMEOUT
);

  localparam int DATA_W = 16;
  localparam logic [COUNT_BITS-1:0] BLANK_C = COUNT_BITS'(BLANK_SAMPLES);
  localparam logic [COUNT_BITS-1:0] MAX_C   = COUNT_BITS'(MAX_SAMPLES);
  localparam logic [15:0]           HOLD_C  = 16'(HOLD_SAMPLES);
  localparam logic [15:0]           WIN_C   = 16'(PEAK_WINDOW);

  typedef enum logic [2:0] {IDLE, BLANK, SEARCH, PEAK, DONE} state_t;

  // Distance of a sample from the ADC zero-signal code. The 17-bit signed
  // difference keeps the full-scale negative case (x = 0) representable.
  function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] x);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] neg;
    diff = $signed({1'b0, x}) - $signed({1'b0, MIDSCALE});
    neg  = -diff;
    return diff[DATA_W] ? neg[DATA_W-1:0] : diff[DATA_W-1:0];
  endfunction

  // Sample index stops at all-ones rather than wrapping.
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + COUNT_BITS'(1);
  endfunction

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                  state;
  logic                    vld_p0;     // read issued last cycle: CHANNEL_DATA holds it now
  logic [COUNT_BITS-1:0]   idx;
  logic [COUNT_BITS-1:0]   cand_tof;
  logic [15:0]             run_cnt;
  logic [15:0]             win_cnt;
  logic [DATA_W-1:0]       peak;

  logic                    cap;
  logic [DATA_W-1:0]       mag;
  logic [DATA_W-1:0]       eval_mag;
  logic                    hit;
  logic [COUNT_BITS-1:0]   idx_nx;
  logic [COUNT_BITS-1:0]   run_tof;
  logic [15:0]             run_nx;
  logic [15:0]             win_nx;
  logic [DATA_W-1:0]       run_pk;
  logic [DATA_W-1:0]       win_pk;
  logic                    run_done;
  logic                    at_max;

  // A new read is never issued while one is in flight, nor in a TX_START
  // cycle, so the only sample that can straddle a restart is the one already
  // on the bus; that one is dropped by gating cap.
  assign READ_REQ = !RST && ON && !TX_START && (state != IDLE) &&
                    !CHANNEL_EMPTY && !vld_p0;
  assign cap      = vld_p0 && ON && !TX_START;
  assign mag      = rectify(CHANNEL_DATA);

`ifdef ECHO_AVG_EN
  logic [DATA_W-1:0] hist_p1 [3];
  logic [DATA_W+1:0] avg_sum;

  assign avg_sum  = {2'b00, mag} + {2'b00, hist_p1[0]} +
                    {2'b00, hist_p1[1]} + {2'b00, hist_p1[2]};
  assign eval_mag = avg_sum[DATA_W+1:2];

  // Magnitude history of evaluated samples; each frame starts from zeros.
  always_ff @(posedge SYS_CLK) begin
    if (ON && TX_START) begin
      hist_p1[0] <= '0;
      hist_p1[1] <= '0;
      hist_p1[2] <= '0;
    end else if (cap && state == SEARCH) begin
      hist_p1[2] <= hist_p1[1];
      hist_p1[1] <= hist_p1[0];
      hist_p1[0] <= mag;
    end
  end
`else
  assign eval_mag = mag;
`endif

  assign hit      = eval_mag > THRESHOLD;
  assign idx_nx   = sat_inc(idx);
  assign run_nx   = run_cnt + 16'd1;
  assign win_nx   = win_cnt + 16'd1;
  assign run_tof  = (run_cnt == 16'd0) ? idx : cand_tof;
  assign run_pk   = (run_cnt == 16'd0) ? mag : umax(peak, mag);
  assign win_pk   = umax(peak, mag);
  assign run_done = hit && (run_nx == HOLD_C);
  assign at_max   = (idx_nx == MAX_C);

  // Frame FSM: read handshake, sample indexing, detection and result pulses.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state      <= IDLE;
      vld_p0     <= 1'b0;
      idx        <= '0;
      run_cnt    <= '0;
      win_cnt    <= '0;
      ECHO_VALID <= 1'b0;
      TIMEOUT    <= 1'b0;
      ECHO_TOF   <= '0;
      ECHO_PEAK  <= '0;
    end else begin
      ECHO_VALID <= 1'b0;
      TIMEOUT    <= 1'b0;
      vld_p0     <= READ_REQ;
      if (!ON) begin
        state  <= IDLE;
        vld_p0 <= 1'b0;
      end else if (TX_START) begin
        state   <= BLANK;
        idx     <= '0;
        run_cnt <= '0;
        win_cnt <= '0;
        peak    <= '0;
      end else begin
        case (state)
          IDLE: ;
          BLANK: begin
            if (cap) begin
              idx <= idx_nx;
              if (idx_nx == BLANK_C) state <= SEARCH;
            end else if (idx == BLANK_C) begin
              state <= SEARCH;
            end
          end
          SEARCH: begin
            if (cap) begin
              idx <= idx_nx;
              if (hit) begin
                run_cnt  <= run_nx;
                peak     <= run_pk;
                cand_tof <= run_tof;
              end else begin
                run_cnt <= '0;
              end
              // A completing run wins over the timeout on the same sample.
              if (run_done) begin
                run_cnt <= '0;
                win_cnt <= '0;
                if (PEAK_WINDOW == 0) begin
                  state      <= DONE;
                  ECHO_VALID <= 1'b1;
                  ECHO_TOF   <= run_tof;
                  ECHO_PEAK  <= run_pk;
                end else begin
                  state <= PEAK;
                end
              end else if (at_max) begin
                state   <= DONE;
                TIMEOUT <= 1'b1;
              end
            end
          end
          PEAK: begin
            if (cap) begin
              idx     <= idx_nx;
              peak    <= win_pk;
              win_cnt <= win_nx;
              if (win_nx == WIN_C) begin
                state      <= DONE;
                ECHO_VALID <= 1'b1;
                ECHO_TOF   <= cand_tof;
                ECHO_PEAK  <= win_pk;
              end
            end
          end
          DONE: begin
            // Keep draining so the channel is empty for the next burst.
            if (cap) idx <= idx_nx;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
